// File: rtl/fetch_unit.sv
// Instruction fetch unit: single outstanding read on a valid/ready address+data bus.
// Optional response timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_fetch,
  input  logic [31:0] pc,
  output logic [31:0] ir_addr,
  output logic        ir_addr_valid,
  input  logic        ir_addr_ready,
  input  logic [31:0] ir_data,
  input  logic        ir_data_valid,
  output logic        ir_data_ready,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        fetch_busy,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic [31:0] r_ir_addr;
  logic        r_addr_valid;
  logic        r_data_ready;
  logic [31:0] r_inst;
  logic        r_inst_valid;
  logic        w_accept;
  logic        w_done;
  logic        w_timeout;
  logic        w_addr_valid_d;
  logic        w_data_ready_d;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      StIdle: begin
        if (inst_fetch) begin
          w_accept  = 1'b1;
          w_state_d = StReq;
        end
      end
      StReq: begin
        if (r_addr_valid && ir_addr_ready) begin
          w_state_d = StWait;
        end
      end
      StWait: begin
        if (ir_data_valid) begin
          w_done    = 1'b1;
          w_state_d = StIdle;
        end else if (w_timeout) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Bus handshake outputs are decoded from the next state and then flopped,
  // so they never see a combinational path from the bus inputs.
  always_comb begin
    w_addr_valid_d = (w_state_d == StReq);
    w_data_ready_d = (w_state_d == StWait);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr_valid <= 1'b0;
      r_data_ready <= 1'b0;
      r_ir_addr    <= 32'h0;
      r_inst       <= 32'h0;
      r_inst_valid <= 1'b0;
    end else begin
      r_addr_valid <= w_addr_valid_d;
      r_data_ready <= w_data_ready_d;
      r_inst_valid <= w_done;
      if (w_accept) begin
        r_ir_addr <= {pc[31:2], 2'b00};
      end
      if (w_done) begin
        r_inst <= ir_data;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] r_cnt;
  logic            r_fetch_err;

  // Fires on the edge that ends the TIMEOUT_CYCLES-th empty wait cycle.
  assign w_timeout = (r_state == StWait) && !ir_data_valid && (r_cnt == CntLast);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      if (r_state != StWait && w_state_d == StWait) begin
        r_cnt <= '0;
      end else if (r_state == StWait && !ir_data_valid && !w_timeout) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_fetch_err <= 1'b1;
      end else if (w_accept) begin
        r_fetch_err <= 1'b0;
      end
    end
  end

  assign fetch_err = r_fetch_err;

  logic w_unused;
  assign w_unused = ^pc[1:0];
`else
  assign w_timeout = 1'b0;
  assign fetch_err = 1'b0;

  logic w_unused;
  assign w_unused = ^{pc[1:0], TIMEOUT_CYCLES[0]};
`endif

  assign ir_addr       = r_ir_addr;
  assign ir_addr_valid = r_addr_valid;
  assign ir_data_ready = r_data_ready;
  assign inst          = r_inst;
  assign inst_valid    = r_inst_valid;
  assign fetch_busy    = (r_state != StIdle);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected instruction words.
// Timeout scenario is compiled in only when FETCH_TIMEOUT_EN is defined.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_fetch;
  logic [31:0] pc;
  logic [31:0] ir_addr;
  logic        ir_addr_valid;
  logic        ir_addr_ready;
  logic [31:0] ir_data;
  logic        ir_data_valid;
  logic        ir_data_ready;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fetch_busy;
  logic        fetch_err;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] exp_q[$];

  fetch_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_fetch   (inst_fetch),
    .pc           (pc),
    .ir_addr      (ir_addr),
    .ir_addr_valid(ir_addr_valid),
    .ir_addr_ready(ir_addr_ready),
    .ir_data      (ir_data),
    .ir_data_valid(ir_data_valid),
    .ir_data_ready(ir_data_ready),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .fetch_busy   (fetch_busy),
    .fetch_err    (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in REQ on return.
  task automatic start_fetch(input logic [31:0] a);
    inst_fetch = 1'b1;
    pc         = a;
    tick();
    inst_fetch = 1'b0;
  endtask

  // Called in WAIT; inst_valid is high on return.
  task automatic respond(input logic [31:0] d);
    ir_data       = d;
    ir_data_valid = 1'b1;
    exp_q.push_back(d);
    tick();
    ir_data_valid = 1'b0;
  endtask

  // Every inst_valid pulse must match the oldest queued response.
  always @(negedge clk) begin
    if (rst === 1'b1 && inst_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_inst_valid", {31'b0, inst_valid}, 32'h0);
      else chk("inst_data", inst, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b0;
    inst_fetch    = 1'b0;
    pc            = 32'h0;
    ir_addr_ready = 1'b1;
    ir_data       = 32'h0;
    ir_data_valid = 1'b0;
    tick();
    tick();
    chk("rst_ir_addr", ir_addr, 32'h0);
    chk("rst_addr_valid", {31'b0, ir_addr_valid}, 32'h0);
    chk("rst_data_ready", {31'b0, ir_data_ready}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_busy", {31'b0, fetch_busy}, 32'h0);
    chk("rst_err", {31'b0, fetch_err}, 32'h0);
    rst = 1'b1;
    tick();

    // Basic fetch with immediate ready and data: inst_valid 3 cycles after request.
    start_fetch(32'h0000_0100);
    chk("t1_req_addr", ir_addr, 32'h0000_0100);
    chk("t1_req_valid", {31'b0, ir_addr_valid}, 32'h1);
    chk("t1_req_busy", {31'b0, fetch_busy}, 32'h1);
    tick();
    chk("t1_wait_dready", {31'b0, ir_data_ready}, 32'h1);
    chk("t1_wait_avalid", {31'b0, ir_addr_valid}, 32'h0);
    chk("t1_wait_noval", {31'b0, inst_valid}, 32'h0);
    respond(32'h0050_0093);
    chk("t1_inst_valid", {31'b0, inst_valid}, 32'h1);
    chk("t1_inst", inst, 32'h0050_0093);
    chk("t1_idle", {31'b0, fetch_busy}, 32'h0);
    tick();
    chk("t1_pulse_end", {31'b0, inst_valid}, 32'h0);
    chk("t1_inst_hold", inst, 32'h0050_0093);

    // Unaligned pc is word-aligned.
    start_fetch(32'h0000_0203);
    chk("t2_align", ir_addr, 32'h0000_0200);
    tick();
    respond(32'h1111_2222);
    tick();

    // Address stall, with an ignored second request during it.
    ir_addr_ready = 1'b0;
    start_fetch(32'h0000_0400);
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_valid", {31'b0, ir_addr_valid}, 32'h1);
      chk("t3_stall_addr", ir_addr, 32'h0000_0400);
      if (i == 2) begin
        inst_fetch = 1'b1;
        pc         = 32'h0000_0800;
      end
      tick();
      inst_fetch = 1'b0;
    end
    chk("t3_still_req", {31'b0, ir_data_ready}, 32'h0);
    ir_addr_ready = 1'b1;
    tick();
    chk("t3_wait", {31'b0, ir_data_ready}, 32'h1);
    chk("t3_addr_kept", ir_addr, 32'h0000_0400);
    respond(32'h3333_4444);
    tick();

    // Stray data in IDLE must not update inst.
    ir_data       = 32'h1234_5678;
    ir_data_valid = 1'b1;
    tick();
    ir_data_valid = 1'b0;
    chk("t4_stray_inst", inst, 32'h3333_4444);
    chk("t4_stray_busy", {31'b0, fetch_busy}, 32'h0);

    // Request coinciding with completion is dropped.
    start_fetch(32'h0000_0600);
    tick();
    inst_fetch = 1'b1;
    pc         = 32'h0000_0900;
    respond(32'h5555_6666);
    inst_fetch = 1'b0;
    chk("t5_no_new_req", {31'b0, fetch_busy}, 32'h0);
    tick();
    chk("t5_no_avalid", {31'b0, ir_addr_valid}, 32'h0);
    chk("t5_addr_kept", ir_addr, 32'h0000_0600);

    // Reset during WAIT, then a late response.
    start_fetch(32'h0000_0500);
    tick();
    chk("t6_in_wait", {31'b0, ir_data_ready}, 32'h1);
    rst = 1'b0;
    tick();
    rst           = 1'b1;
    ir_data       = 32'hDEAD_BEEF;
    ir_data_valid = 1'b1;
    tick();
    ir_data_valid = 1'b0;
    tick();
    chk("t6_inst_zero", inst, 32'h0);
    chk("t6_no_valid", {31'b0, inst_valid}, 32'h0);
    chk("t6_idle", {31'b0, fetch_busy}, 32'h0);
    chk("t6_addr_zero", ir_addr, 32'h0);

`ifdef FETCH_TIMEOUT_EN
    // Timeout after 8 empty WAIT cycles; next request clears the error.
    start_fetch(32'h0000_0700);
    tick();
    for (int i = 0; i < 7; i++) begin
      chk("t7_waiting", {31'b0, fetch_busy}, 32'h1);
      chk("t7_no_err", {31'b0, fetch_err}, 32'h0);
      tick();
    end
    chk("t7_last_wait", {31'b0, fetch_busy}, 32'h1);
    tick();
    chk("t7_err_set", {31'b0, fetch_err}, 32'h1);
    chk("t7_idle", {31'b0, fetch_busy}, 32'h0);
    chk("t7_no_valid", {31'b0, inst_valid}, 32'h0);
    tick();
    chk("t7_err_sticky", {31'b0, fetch_err}, 32'h1);
    start_fetch(32'h0000_0704);
    chk("t7_err_clear", {31'b0, fetch_err}, 32'h0);
    tick();
    respond(32'h7777_8888);
    tick();
`else
    // Without the timeout, WAIT holds indefinitely.
    start_fetch(32'h0000_0700);
    tick();
    for (int i = 0; i < 20; i++) tick();
    chk("t7_still_wait", {31'b0, ir_data_ready}, 32'h1);
    chk("t7_err_zero", {31'b0, fetch_err}, 32'h0);
    respond(32'h7777_8888);
    tick();
`endif

    chk("sb_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, response-wait cycles before a fetch is abandoned (used only with FETCH_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset: synchronous, active-low.
REQ-004 SHALL have port inst_fetch  input  1  one-cycle request pulse from control_unit.
REQ-005 SHALL have port pc  input  32  address of the instruction to fetch, sampled with inst_fetch.
REQ-006 SHALL have port ir_addr  output  32  bus read address.
REQ-007 SHALL have port ir_addr_valid  output  1  address channel valid.
REQ-008 SHALL have port ir_addr_ready  input  1  address channel ready.
REQ-009 SHALL have port ir_data  input  32  bus read data.
REQ-010 SHALL have port ir_data_valid  input  1  data channel valid.
REQ-011 SHALL have port ir_data_ready  output  1  data channel ready.
REQ-012 SHALL have port inst  output  32  last fetched instruction word.
REQ-013 SHALL have port inst_valid  output  1  one-cycle pulse: inst is new.
REQ-014 SHALL have port fetch_busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port fetch_err  output  1  sticky timeout flag.

Function
REQ-016 SHALL implement states IDLE, REQ, WAIT.
REQ-017 IDLE: on inst_fetch=1, SHALL register ir_addr = {pc[31:2],2'b00} and move to REQ next cycle.
REQ-018 REQ: ir_addr_valid=1; ir_addr stable; on ir_addr_valid&&ir_addr_ready SHALL move to WAIT.
REQ-019 WAIT: ir_data_ready=1; on ir_data_valid SHALL register inst=ir_data, pulse inst_valid for exactly the next cycle, return to IDLE.
REQ-020 Latency: ready on first REQ cycle and data on first WAIT cycle -> inst_valid high 3 cycles after the inst_fetch cycle.
REQ-021 inst_fetch while not IDLE SHALL be ignored (no queueing, no address change).
REQ-022 ir_data_valid outside WAIT SHALL be ignored; inst unchanged.
REQ-023 inst SHALL hold its value until the next accepted response.
REQ-024 ir_addr_valid and ir_data_ready SHALL be registered outputs, never combinationally dependent on bus inputs.
REQ-025 inst_fetch in the same cycle as the WAIT->IDLE completion SHALL be ignored.

Reset
REQ-026 rst=0 at a clock edge SHALL force IDLE, ir_addr=0, ir_addr_valid=0, ir_data_ready=0, inst=0, inst_valid=0, fetch_err=0, timeout counter=0.
REQ-027 Reset mid-transaction SHALL abandon it; a response arriving after reset release SHALL be ignored per REQ-022.

Configuration
REQ-028 Macro FETCH_TIMEOUT_EN defined: counter clears on WAIT entry, increments each WAIT cycle without ir_data_valid; on reaching TIMEOUT_CYCLES SHALL set fetch_err=1, return to IDLE, no inst_valid.
REQ-029 fetch_err SHALL clear on the next accepted inst_fetch or reset.
REQ-030 Macro undefined: no counter, fetch_err tied 0, WAIT holds indefinitely.

Verification
REQ-031 pc=0x100, ready and data=0x00500093 immediate -> ir_addr=0x100, inst=0x00500093, inst_valid one pulse 3 cycles after inst_fetch.
REQ-032 pc=0x203 -> ir_addr=0x200.
REQ-033 ir_addr_ready low 5 cycles -> ir_addr_valid held, ir_addr stable, then WAIT; second inst_fetch during stall has no effect.
REQ-034 rst=0 in WAIT, then data_valid=1 with 0xDEADBEEF after release -> inst=0, no inst_valid.
REQ-035 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, no data -> fetch_err=1 after 8 WAIT cycles, IDLE; next inst_fetch clears fetch_err.
